// File: rtl/data_axi_bridge.sv
// -----------------------------------------------------------------------------
// data_axi_bridge
//
// Converts the pipeline's single-cycle data-memory request into one AXI4 read
// or write transaction at a time. The pipeline is stalled while a
// transaction is in flight. Load data is registered and presented on the
// cycle after the R handshake.
//
// The fixed AXI attributes (ID, len = 0, burst, size = word) and the unused
// rresp/bresp are tied off at the integrating top level, so they are not
// ports of this block.
//
// Ports
//   clk              in   single clock, rising edge
//   reset            in   asynchronous, active-high reset
//   data_sram_en     in   pipeline request valid
//   data_sram_we     in   [3:0] byte write enables (0 = load)
//   data_sram_addr   in   [31:0] byte address
//   data_sram_wdata  in   [31:0] store data, byte-lane aligned
//   data_sram_rdata  out  [31:0] registered load data
//   stallreq_axi     out  pipeline stall request (combinational)
//   arvalid/arready  out/in   read-address handshake, araddr out [31:0]
//   rvalid/rready    in/out   read-data handshake, rdata in [31:0]
//   awvalid/awready  out/in   write-address handshake, awaddr out [31:0]
//   wvalid/wready    out/in   write-data handshake, wdata out [31:0],
//                             wstrb out [3:0]
//   bvalid/bready    in/out   write-response handshake
// -----------------------------------------------------------------------------
module data_axi_bridge (
    input  logic        clk,
    input  logic        reset,

    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_we,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic        stallreq_axi,

    output logic        arvalid,
    input  logic        arready,
    output logic [31:0] araddr,

    input  logic        rvalid,
    output logic        rready,
    input  logic [31:0] rdata,

    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] awaddr,

    output logic        wvalid,
    input  logic        wready,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,

    input  logic        bvalid,
    output logic        bready
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        AR   = 3'd1,
        R    = 3'd2,
        AWW  = 3'd3,
        B    = 3'd4,
        DONE = 3'd5
    } state_t;

    state_t      state;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;

    // Within AWW a channel counts as complete if its valid has already been
    // dropped (handshake in an earlier cycle) or it is handshaking right now.
    // This lets both channels finish in the same cycle or in either order.
    logic aw_ok;
    logic w_ok;

    assign aw_ok = ~awvalid | awready;
    assign w_ok  = ~wvalid  | wready;

    // Address, data and strobes come straight from the latched request, so
    // they are stable for as long as the corresponding valid is high.
    assign araddr = addr_q;
    assign awaddr = addr_q;
    assign wdata  = wdata_q;
    assign wstrb  = wstrb_q;

    // Stall goes high in the same cycle the request appears so the pipeline
    // holds it; it is released in DONE, where the load data is already valid.
    assign stallreq_axi = ((state == IDLE) & data_sram_en)
                        | (state == AR)
                        | (state == R)
                        | (state == AWW)
                        | (state == B);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            addr_q          <= 32'h0;
            wdata_q         <= 32'h0;
            wstrb_q         <= 4'h0;
            data_sram_rdata <= 32'h0;
            arvalid         <= 1'b0;
            rready          <= 1'b0;
            awvalid         <= 1'b0;
            wvalid          <= 1'b0;
            bready          <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (data_sram_en) begin
                        addr_q <= data_sram_addr;
                        if (data_sram_we == 4'h0) begin
                            arvalid <= 1'b1;
                            state   <= AR;
                        end else begin
                            wdata_q <= data_sram_wdata;
                            wstrb_q <= data_sram_we;
                            awvalid <= 1'b1;
                            wvalid  <= 1'b1;
                            state   <= AWW;
                        end
                    end
                end

                AR: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        state   <= R;
                    end
                end

                R: begin
                    if (rvalid) begin
                        data_sram_rdata <= rdata;
                        rready          <= 1'b0;
                        state           <= DONE;
                    end
                end

                AWW: begin
                    if (awvalid && awready) begin
                        awvalid <= 1'b0;
                    end
                    if (wvalid && wready) begin
                        wvalid <= 1'b0;
                    end
                    if (aw_ok && w_ok) begin
                        bready <= 1'b1;
                        state  <= B;
                    end
                end

                B: begin
                    if (bvalid) begin
                        bready <= 1'b0;
                        state  <= DONE;
                    end
                end

                DONE: begin
                    // The request still on data_sram_en is the one that just
                    // finished; the pipeline advances this cycle.
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_axi_bridge.sv
module tb_data_axi_bridge;

    logic        clk;
    logic        reset;
    logic        data_sram_en;
    logic [3:0]  data_sram_we;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;
    logic        stallreq_axi;
    logic        arvalid, arready;
    logic [31:0] araddr;
    logic        rvalid, rready;
    logic [31:0] rdata;
    logic        awvalid, awready;
    logic [31:0] awaddr;
    logic        wvalid, wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        bvalid, bready;

    int n_cmp  = 0;
    int n_fail = 0;

    // Protocol monitor state
    int          stab_err    = 0;
    int          overlap_err = 0;
    int          aw_hs_cnt   = 0;
    int          w_hs_cnt    = 0;
    logic        p_ar = 1'b0, p_aw = 1'b0, p_w = 1'b0;
    logic [31:0] p_araddr = 32'h0, p_awaddr = 32'h0, p_wdata = 32'h0;
    logic [3:0]  p_wstrb = 4'h0;

    data_axi_bridge dut (
        .clk             (clk),
        .reset           (reset),
        .data_sram_en    (data_sram_en),
        .data_sram_we    (data_sram_we),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata),
        .data_sram_rdata (data_sram_rdata),
        .stallreq_axi    (stallreq_axi),
        .arvalid         (arvalid),
        .arready         (arready),
        .araddr          (araddr),
        .rvalid          (rvalid),
        .rready          (rready),
        .rdata           (rdata),
        .awvalid         (awvalid),
        .awready         (awready),
        .awaddr          (awaddr),
        .wvalid          (wvalid),
        .wready          (wready),
        .wdata           (wdata),
        .wstrb           (wstrb),
        .bvalid          (bvalid),
        .bready          (bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Valid/payload stability, handshake counting and read/write overlap.
    always @(posedge clk) begin
        if (reset) begin
            p_ar <= 1'b0;
            p_aw <= 1'b0;
            p_w  <= 1'b0;
        end else begin
            if ((p_ar && (arvalid !== 1'b1 || araddr !== p_araddr)) ||
                (p_aw && (awvalid !== 1'b1 || awaddr !== p_awaddr)) ||
                (p_w  && (wvalid !== 1'b1 || wdata !== p_wdata || wstrb !== p_wstrb)))
                stab_err <= stab_err + 1;
            if ((arvalid || rready) && (awvalid || wvalid || bready))
                overlap_err <= overlap_err + 1;
            if (awvalid && awready) aw_hs_cnt <= aw_hs_cnt + 1;
            if (wvalid && wready)   w_hs_cnt  <= w_hs_cnt + 1;
            p_ar     <= arvalid && !arready;
            p_aw     <= awvalid && !awready;
            p_w      <= wvalid && !wready;
            p_araddr <= araddr;
            p_awaddr <= awaddr;
            p_wdata  <= wdata;
            p_wstrb  <= wstrb;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        data_sram_en    = 1'b0;
        data_sram_we    = 4'h0;
        data_sram_addr  = 32'h0;
        data_sram_wdata = 32'h0;
        arready = 1'b0;
        rvalid  = 1'b0;
        rdata   = 32'h0;
        awready = 1'b0;
        wready  = 1'b0;
        bvalid  = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        tick();
        tick();
        #1;
        n_cmp++;
        if ({arvalid, rready, awvalid, wvalid, bready} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_valids: got %b expected 00000", {arvalid, rready, awvalid, wvalid, bready});
        end
        n_cmp++;
        if (data_sram_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_rdata: got %h expected 00000000", data_sram_rdata);
        end
        n_cmp++;
        if (stallreq_axi !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_stall_en0: got %b expected 0", stallreq_axi);
        end
        data_sram_en = 1'b1;
        #1;
        n_cmp++;
        if (stallreq_axi !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_stall_en1: got %b expected 1", stallreq_axi);
        end
        data_sram_en = 1'b0;
        #1;
        reset = 1'b0;
    endtask

    // Zero-wait load: IDLE, AR, R stall; data visible in DONE.
    task automatic test_load();
        tick();
        data_sram_en = 1'b1; data_sram_we = 4'h0; data_sram_addr = 32'h1000_0004;
        arready = 1'b1;
        #1;
        n_cmp++;
        if (stallreq_axi !== 1'b1 || arvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL load_idle: stall=%b arvalid=%b expected stall=1 arvalid=0", stallreq_axi, arvalid);
        end
        tick();
        rvalid = 1'b1; rdata = 32'hDEAD_BEEF;
        #1;
        n_cmp++;
        if (arvalid !== 1'b1 || araddr !== 32'h1000_0004 || rready !== 1'b0 || stallreq_axi !== 1'b1) begin
            n_fail++;
            $display("FAIL load_ar: arvalid=%b araddr=%h rready=%b stall=%b expected 1 10000004 0 1",
                     arvalid, araddr, rready, stallreq_axi);
        end
        tick();
        #1;
        n_cmp++;
        if (rready !== 1'b1 || arvalid !== 1'b0 || stallreq_axi !== 1'b1) begin
            n_fail++;
            $display("FAIL load_r: rready=%b arvalid=%b stall=%b expected 1 0 1", rready, arvalid, stallreq_axi);
        end
        tick();
        #1;
        n_cmp++;
        if (stallreq_axi !== 1'b0 || data_sram_rdata !== 32'hDEAD_BEEF || rready !== 1'b0) begin
            n_fail++;
            $display("FAIL load_done: stall=%b rdata=%h rready=%b expected 0 deadbeef 0",
                     stallreq_axi, data_sram_rdata, rready);
        end
        idle_inputs();
    endtask

    // AW accepted two cycles before W.
    task automatic test_store_aw_first();
        int aw0, w0;
        aw0 = aw_hs_cnt;
        w0  = w_hs_cnt;
        tick();
        data_sram_en = 1'b1; data_sram_we = 4'b0011;
        data_sram_addr = 32'h0000_0008; data_sram_wdata = 32'h1234_5678;
        #1;
        n_cmp++;
        if (stallreq_axi !== 1'b1) begin
            n_fail++;
            $display("FAIL st1_idle_stall: got %b expected 1", stallreq_axi);
        end
        tick();
        awready = 1'b1;
        #1;
        n_cmp++;
        if (awvalid !== 1'b1 || wvalid !== 1'b1 || awaddr !== 32'h8 || wdata !== 32'h1234_5678 || wstrb !== 4'b0011) begin
            n_fail++;
            $display("FAIL st1_aww_entry: awv=%b wv=%b awaddr=%h wdata=%h wstrb=%b expected 1 1 00000008 12345678 0011",
                     awvalid, wvalid, awaddr, wdata, wstrb);
        end
        tick();
        awready = 1'b0;
        #1;
        n_cmp++;
        if (awvalid !== 1'b0 || wvalid !== 1'b1 || bready !== 1'b0 || stallreq_axi !== 1'b1) begin
            n_fail++;
            $display("FAIL st1_aw_dropped: awv=%b wv=%b bready=%b stall=%b expected 0 1 0 1",
                     awvalid, wvalid, bready, stallreq_axi);
        end
        tick();
        wready = 1'b1;
        #1;
        n_cmp++;
        if (wvalid !== 1'b1 || bready !== 1'b0) begin
            n_fail++;
            $display("FAIL st1_w_wait: wv=%b bready=%b expected 1 0", wvalid, bready);
        end
        tick();
        wready = 1'b0; bvalid = 1'b1;
        #1;
        n_cmp++;
        if (wvalid !== 1'b0 || awvalid !== 1'b0 || bready !== 1'b1) begin
            n_fail++;
            $display("FAIL st1_b: wv=%b awv=%b bready=%b expected 0 0 1", wvalid, awvalid, bready);
        end
        tick();
        bvalid = 1'b0;
        #1;
        n_cmp++;
        if (stallreq_axi !== 1'b0 || bready !== 1'b0 || data_sram_rdata !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL st1_done: stall=%b bready=%b rdata=%h expected 0 0 deadbeef",
                     stallreq_axi, bready, data_sram_rdata);
        end
        n_cmp++;
        if (aw_hs_cnt - aw0 !== 1 || w_hs_cnt - w0 !== 1) begin
            n_fail++;
            $display("FAIL st1_hs_count: aw=%0d w=%0d expected 1 1", aw_hs_cnt - aw0, w_hs_cnt - w0);
        end
        idle_inputs();
    endtask

    // AW and W accepted together; B lasts five cycles.
    task automatic test_store_same_cycle();
        int stall_cnt, bready_cnt;
        bit done;
        stall_cnt = 0; bready_cnt = 0; done = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick();
            data_sram_en = 1'b1; data_sram_we = 4'b1111;
            data_sram_addr = 32'h0000_0020; data_sram_wdata = 32'hA5A5_A5A5;
            awready = 1'b1; wready = 1'b1;
            bvalid = (c == 6);
            #1;
            if (stallreq_axi) stall_cnt++;
            if (bready) bready_cnt++;
            if (c == 1) begin
                n_cmp++;
                if (awvalid !== 1'b1 || wvalid !== 1'b1 || wstrb !== 4'b1111) begin
                    n_fail++;
                    $display("FAIL st2_aww: awv=%b wv=%b wstrb=%b expected 1 1 1111", awvalid, wvalid, wstrb);
                end
            end
            if (c > 0 && !stallreq_axi) begin
                done = 1'b1;
                break;
            end
        end
        idle_inputs();
        n_cmp++;
        if (!done || stall_cnt != 7) begin
            n_fail++;
            $display("FAIL st2_stall_cycles: got %0d (done=%0b) expected 7", stall_cnt, done);
        end
        n_cmp++;
        if (bready_cnt != 5) begin
            n_fail++;
            $display("FAIL st2_bready_cycles: got %0d expected 5", bready_cnt);
        end
    endtask

    // arready withheld for four AR cycles.
    task automatic test_load_delay();
        int stall_cnt;
        bit done;
        stall_cnt = 0; done = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick();
            data_sram_en = 1'b1; data_sram_we = 4'h0; data_sram_addr = 32'h0000_0200;
            arready = (c == 5);
            rvalid  = (c == 6);
            rdata   = 32'h0BAD_F00D;
            #1;
            if (stallreq_axi) stall_cnt++;
            if (c >= 1 && c <= 5) begin
                n_cmp++;
                if (arvalid !== 1'b1 || araddr !== 32'h200 || rready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL ld2_ar_cycle%0d: arvalid=%b araddr=%h rready=%b expected 1 00000200 0",
                             c, arvalid, araddr, rready);
                end
            end
            if (c > 0 && !stallreq_axi) begin
                done = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (!done || stall_cnt != 7 || data_sram_rdata !== 32'h0BAD_F00D) begin
            n_fail++;
            $display("FAIL ld2_done: stall_cycles=%0d done=%0b rdata=%h expected 7 1 0badf00d",
                     stall_cnt, done, data_sram_rdata);
        end
        idle_inputs();
    endtask

    // Load then store with en held high across DONE.
    task automatic test_back_to_back();
        for (int c = 0; c < 8; c++) begin
            tick();
            data_sram_en = 1'b1;
            if (c < 3) begin
                data_sram_we = 4'h0; data_sram_addr = 32'h0000_0040;
            end else begin
                data_sram_we = 4'b1111; data_sram_addr = 32'h0000_0044;
                data_sram_wdata = 32'h1111_2222;
            end
            arready = 1'b1; rvalid = 1'b1; rdata = 32'hCAFE_F00D;
            awready = 1'b1; wready = 1'b1; bvalid = 1'b1;
            #1;
            if (c == 3) begin
                n_cmp++;
                if (stallreq_axi !== 1'b0 || data_sram_rdata !== 32'hCAFE_F00D || awvalid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL b2b_done: stall=%b rdata=%h awvalid=%b expected 0 cafef00d 0",
                             stallreq_axi, data_sram_rdata, awvalid);
                end
            end
            if (c == 4) begin
                n_cmp++;
                if (stallreq_axi !== 1'b1 || awvalid !== 1'b0 || arvalid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL b2b_idle: stall=%b awvalid=%b arvalid=%b expected 1 0 0",
                             stallreq_axi, awvalid, arvalid);
                end
            end
            if (c == 5) begin
                n_cmp++;
                if (awvalid !== 1'b1 || awaddr !== 32'h44 || wdata !== 32'h1111_2222) begin
                    n_fail++;
                    $display("FAIL b2b_store: awvalid=%b awaddr=%h wdata=%h expected 1 00000044 11112222",
                             awvalid, awaddr, wdata);
                end
            end
            if (c == 7) begin
                n_cmp++;
                if (stallreq_axi !== 1'b0 || data_sram_rdata !== 32'hCAFE_F00D) begin
                    n_fail++;
                    $display("FAIL b2b_store_done: stall=%b rdata=%h expected 0 cafef00d",
                             stallreq_axi, data_sram_rdata);
                end
                idle_inputs();
            end
        end
    endtask

    // Reset while waiting in R, then a clean load.
    task automatic test_reset_mid();
        tick();
        data_sram_en = 1'b1; data_sram_we = 4'h0; data_sram_addr = 32'h0000_0050;
        arready = 1'b1;
        #1;
        tick();   // AR
        tick();   // R, no rvalid yet
        #1;
        n_cmp++;
        if (rready !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_in_r: rready=%b expected 1", rready);
        end
        reset = 1'b1;
        #1;
        n_cmp++;
        if (rready !== 1'b0 || data_sram_rdata !== 32'h0 || stallreq_axi !== 1'b1 || arvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_async: rready=%b rdata=%h stall=%b arvalid=%b expected 0 00000000 1 0",
                     rready, data_sram_rdata, stallreq_axi, arvalid);
        end
        rvalid = 1'b1; rdata = 32'hFFFF_FFFF;
        tick();
        rvalid = 1'b0; data_sram_en = 1'b0; arready = 1'b0;
        reset = 1'b0;
        tick();
        #1;
        n_cmp++;
        if (stallreq_axi !== 1'b0 || arvalid !== 1'b0 || rready !== 1'b0 || data_sram_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL rst_mid_no_resume: stall=%b arvalid=%b rready=%b rdata=%h expected 0 0 0 00000000",
                     stallreq_axi, arvalid, rready, data_sram_rdata);
        end
        for (int c = 0; c < 4; c++) begin
            if (c > 0) tick();
            data_sram_en = 1'b1; data_sram_we = 4'h0; data_sram_addr = 32'h0000_0060;
            arready = 1'b1; rvalid = 1'b1; rdata = 32'h7654_3210;
            #1;
            if (c == 1) begin
                n_cmp++;
                if (arvalid !== 1'b1 || araddr !== 32'h60) begin
                    n_fail++;
                    $display("FAIL rst_mid_reload_ar: arvalid=%b araddr=%h expected 1 00000060", arvalid, araddr);
                end
            end
            if (c == 3) begin
                n_cmp++;
                if (stallreq_axi !== 1'b0 || data_sram_rdata !== 32'h7654_3210) begin
                    n_fail++;
                    $display("FAIL rst_mid_reload_done: stall=%b rdata=%h expected 0 76543210",
                             stallreq_axi, data_sram_rdata);
                end
            end
        end
        idle_inputs();
    endtask

    task automatic test_protocol();
        tick();
        n_cmp++;
        if (stab_err != 0) begin
            n_fail++;
            $display("FAIL valid_stability: got %0d violations expected 0", stab_err);
        end
        n_cmp++;
        if (overlap_err != 0) begin
            n_fail++;
            $display("FAIL rd_wr_overlap: got %0d cycles expected 0", overlap_err);
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_store_aw_first();
        test_store_same_cycle();
        test_load_delay();
        test_back_to_back();
        test_reset_mid();
        test_protocol();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/data_axi_bridge.md
DATA_AXI_BRIDGE -- requirements
Module: data_axi_bridge

Interface
REQ-001 The module SHALL have no parameters; AXI ID, len (0), burst and size (word) are tied constant at top level.
REQ-002 The port list SHALL start with clk  in  1  single clock; all logic on its rising edge.
REQ-003 The next port SHALL be reset  in  1  asynchronous, active-high reset.
REQ-004 data_sram_en  in  1  pipeline data-memory request valid.
REQ-005 data_sram_we  in  4  byte write enables; 0 = load, nonzero = store.
REQ-006 data_sram_addr  in  32  byte address.
REQ-007 data_sram_wdata  in  32  store data, byte-lane aligned.
REQ-008 data_sram_rdata  out  32  registered load data, full word.
REQ-009 stallreq_axi  out  1  pipeline stall request.
REQ-010 arvalid, arready (out, in; 1 each)  read-address handshake.
REQ-011 araddr  out  32  read address.
REQ-012 rvalid, rready (in, out; 1 each)  read-data handshake.
REQ-013 rdata  in  32  read data; rresp is not connected.
REQ-014 awvalid, awready (out, in; 1 each)  write-address handshake.
REQ-015 awaddr  out  32  write address.
REQ-016 wvalid, wready (out, in; 1 each)  write-data handshake.
REQ-017 wdata  out  32  write data.
REQ-018 wstrb  out  4  write strobes.
REQ-019 bvalid, bready (in, out; 1 each)  write-response handshake; bresp is not connected.

Function
REQ-020 The FSM SHALL have the states IDLE, AR, R, AWW, B and DONE.
REQ-021 In IDLE with data_sram_en=1 and we=0, the block SHALL latch addr and go to AR.
REQ-022 In IDLE with data_sram_en=1 and we!=0, the block SHALL latch addr, wdata and we, and go to AWW.
REQ-023 In AR, arvalid SHALL be 1 with araddr=latched addr; on arready the FSM goes to R.
REQ-024 In R, rready SHALL be 1; on rvalid, data_sram_rdata<=rdata and the FSM goes to DONE.
REQ-025 On entering AWW, awvalid and wvalid SHALL both be 1; each drops independently after its handshake.
REQ-026 The FSM SHALL leave AWW for B only once both the AW and W handshakes have completed, including when both complete in the same cycle.
REQ-027 In B, bready SHALL be 1; on bvalid the FSM goes to DONE.
REQ-028 In DONE, the FSM SHALL go to IDLE unconditionally, and data_sram_en SHALL be ignored because the request is the one just completed.
REQ-029 stallreq_axi SHALL be combinational: (IDLE & data_sram_en) | state in {AR, R, AWW, B}; it is 0 in DONE.
REQ-030 data_sram_rdata SHALL change only on an R handshake; stores leave it unchanged.
REQ-031 Valids SHALL be held stable until their ready is received, and address/data/strobe SHALL be held stable while valid is asserted.
REQ-032 Read latency with zero-wait slave: stall is high for 3 cycles (IDLE, AR, R) and rdata is valid in DONE, the 4th cycle.
REQ-033 Store latency with zero-wait slave: stall is high for 3 cycles (IDLE, AWW, B) and low in DONE.
REQ-034 Only one transaction SHALL be outstanding at a time, and read/write SHALL never overlap.

Reset
REQ-035 On reset, asynchronously and at any time including mid-transaction: state=IDLE, all valid/ready outputs=0, data_sram_rdata=0, latched registers=0, stallreq_axi=data_sram_en.
REQ-036 An AXI transaction aborted by reset SHALL NOT be resumed after reset deasserts.

Verification
REQ-037 Load addr 0x1000_0004 with arready=1 and rvalid next cycle with rdata 0xDEADBEEF -> araddr=0x1000_0004; stall high 3 cycles; data_sram_rdata=0xDEADBEEF in DONE.
REQ-038 Store we=4'b0011, addr 0x8, wdata 0x1234_5678, with awready 2 cycles before wready -> awvalid drops first; W handshake once; wstrb=0011; B entered only after both handshakes.
REQ-039 Store with awready and wready in the same cycle, then bvalid delayed 5 cycles -> stall high 7 cycles; bready held high through B.
REQ-040 Load with arready delayed 4 cycles -> arvalid and araddr stable throughout; no rready before AR completes.
REQ-041 Back-to-back load then store with en held high -> DONE ignores en; the second request starts from IDLE; rdata is unchanged by the store.
REQ-042 Reset asserted while in R -> immediate IDLE, rready=0, data_sram_rdata=0; the next load completes normally.
